// File: rtl/sc_pkg.sv
// Shared types and helpers for the stochastic-computing stream decoder.
// Optional bipolar output is enabled with SC_STREAM_DECODER_BIPOLAR_EN.
package sc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } sc_dec_state_t;

    localparam int SC_DEF_N_BITS = 6;
    localparam int SC_DEF_CNT_W  = SC_DEF_N_BITS + 1;

    function automatic int sc_window_len(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/sc_window_counter.sv
// Window bit counter: counts accepted bits and flags the final bit of a window.
// Part of the stream decoder (see SC_STREAM_DECODER_BIPOLAR_EN in the top).
module sc_window_counter
    import sc_pkg::*;
#(
    parameter int N_BITS = SC_DEF_N_BITS
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic last
);

    localparam int L = sc_window_len(N_BITS);

    logic [N_BITS-1:0] cnt_q;

    // Wraps back to 0 on the last bit, so a new window starts clean.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (inc) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign last = inc && (cnt_q == N_BITS'(L - 1));

endmodule

// File: rtl/sc_stream_decoder.sv
// Stochastic-to-binary decoder: counts ones over a 2**N_BITS bit window.
// Define SC_STREAM_DECODER_BIPOLAR_EN to add the signed bipolar value port.
module sc_stream_decoder
    import sc_pkg::*;
#(
    parameter int N_BITS = SC_DEF_N_BITS,
    parameter int CNT_W  = N_BITS + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    x,
    input  logic                    x_valid,
    output logic                    x_ready,
    output logic                    busy,
    output logic [CNT_W-1:0]        count,
    output logic                    out_valid,
    input  logic                    out_ready
`ifdef SC_STREAM_DECODER_BIPOLAR_EN
    ,
    output logic signed [CNT_W:0]   value
`endif
);

    localparam int L = sc_window_len(N_BITS);

    sc_dec_state_t    state_q;
    logic [CNT_W-1:0] ones_q;
    logic [CNT_W-1:0] count_q;
    logic             out_valid_q;
    logic             x_ready_q;
    logic             busy_q;

    logic             acc_en;
    logic             win_clear;
    logic             last_bit;
    logic [CNT_W-1:0] ones_d;

    assign acc_en    = (state_q == ACCUM) && x_valid;
    assign win_clear = start && ((state_q == IDLE) ||
                                 ((state_q == HOLD) && out_ready));
    assign ones_d    = ones_q + CNT_W'(x);

    sc_window_counter #(
        .N_BITS(N_BITS)
    ) u_bit_cnt (
        .clk  (clk),
        .reset(reset),
        .clear(win_clear),
        .inc  (acc_en),
        .last (last_bit)
    );

`ifdef SC_STREAM_DECODER_BIPOLAR_EN
    logic signed [CNT_W:0] value_q;
    logic        [CNT_W:0] value_d;

    // Modular arithmetic: 2*count - L always lands in -L..+L.
    assign value_d = {ones_d, 1'b0} - (CNT_W + 1)'(L);
    assign value   = value_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= '0;
        end else if (acc_en && last_bit) begin
            value_q <= value_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ones_q      <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            x_ready_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= ACCUM;
                        ones_q    <= '0;
                        x_ready_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (x_valid) begin
                        ones_q <= ones_d;
                        if (last_bit) begin
                            state_q     <= HOLD;
                            count_q     <= ones_d;
                            out_valid_q <= 1'b1;
                            x_ready_q   <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (start) begin
                            state_q   <= ACCUM;
                            ones_q    <= '0;
                            x_ready_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    x_ready_q   <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign count     = count_q;
    assign out_valid = out_valid_q;
    assign x_ready   = x_ready_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Directed bench for sc_stream_decoder with N_BITS=4 (L=16).
// Checks value as well when SC_STREAM_DECODER_BIPOLAR_EN is defined.
module tb_sc_stream_decoder;

    localparam int N_BITS = 4;
    localparam int CNT_W  = N_BITS + 1;
    localparam int L      = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             x = 1'b0;
    logic             x_valid = 1'b0;
    logic             x_ready;
    logic             busy;
    logic [CNT_W-1:0] count;
    logic             out_valid;
    logic             out_ready = 1'b0;
`ifdef SC_STREAM_DECODER_BIPOLAR_EN
    logic signed [CNT_W:0] value;
`endif

    int n_checks = 0;
    int n_errors = 0;

    sc_stream_decoder #(
        .N_BITS(N_BITS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .x        (x),
        .x_valid  (x_valid),
        .x_ready  (x_ready),
        .busy     (busy),
        .count    (count),
        .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef SC_STREAM_DECODER_BIPOLAR_EN
        ,
        .value    (value)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then read 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        x_valid = 1'b1;
        x       = b;
        step();
        x_valid = 1'b0;
        x       = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_ov_after_hs"}, int'(out_valid), 0);
        chk({tag, "_busy_after_hs"}, int'(busy), 0);
    endtask

    task automatic chk_value(input string tag, input int exp);
`ifdef SC_STREAM_DECODER_BIPOLAR_EN
        chk(tag, int'(value), exp);
`else
        if (exp > L) $display("note: %s bipolar check skipped", tag);
`endif
    endtask

    initial begin
        // Reset state
        step();
        step();
        reset = 1'b0;
        chk("rst_count", int'(count), 0);
        chk("rst_ov", int'(out_valid), 0);
        chk("rst_xr", int'(x_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk_value("rst_value", 0);

        // Window of all ones: count = L, no overflow
        pulse_start();
        chk("t1_xr", int'(x_ready), 1);
        chk("t1_busy", int'(busy), 1);
        for (int i = 0; i < L; i++) begin
            if (i == L - 1) chk("t1_ov_pre", int'(out_valid), 0);
            send_bit(1'b1);
        end
        chk("t1_ov", int'(out_valid), 1);
        chk("t1_count", int'(count), 16);
        chk("t1_xr_hold", int'(x_ready), 0);
        chk_value("t1_value", 16);
        handshake("t1");
        chk("t1_count_kept", int'(count), 16);

        // Alternating bits with 3-cycle stalls; x=1 during stalls
        pulse_start();
        for (int i = 0; i < L; i++) begin
            send_bit(((i % 2) == 0) ? 1'b1 : 1'b0);
            if (i != L - 1) begin
                for (int g = 0; g < 3; g++) begin
                    x = 1'b1;
                    step();
                end
                x = 1'b0;
                if (i == 7) chk("t2_ov_mid", int'(out_valid), 0);
            end
        end
        chk("t2_ov", int'(out_valid), 1);
        chk("t2_count", int'(count), 8);
        chk_value("t2_value", 0);
        handshake("t2");

        // All zeros, long HOLD with ignored start and ignored x
        pulse_start();
        for (int i = 0; i < L; i++) send_bit(1'b0);
        for (int c = 0; c < 10; c++) begin
            chk("t3_ov_hold", int'(out_valid), 1);
            chk("t3_count_hold", int'(count), 0);
            chk("t3_xr_hold", int'(x_ready), 0);
            start   = (c == 5);
            x_valid = 1'b1;
            x       = 1'b1;
            step();
        end
        start   = 1'b0;
        x_valid = 1'b0;
        x       = 1'b0;
        chk("t3_busy_hold", int'(busy), 1);
        chk_value("t3_value", -16);
        handshake("t3");

        // IDLE ignores bits; start-cycle bit is not sampled
        x_valid = 1'b1;
        x       = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("t6_xr_idle", int'(x_ready), 0);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < L; i++) send_bit(i < 2);
        chk("t6_count", int'(count), 2);

        // Back-to-back windows: handshake and start together
        out_ready = 1'b1;
        start     = 1'b1;
        step();
        out_ready = 1'b0;
        start     = 1'b0;
        chk("t4_ov_b2b", int'(out_valid), 0);
        chk("t4_xr_b2b", int'(x_ready), 1);
        chk("t4_busy_b2b", int'(busy), 1);
        for (int i = 0; i < L; i++) send_bit((i % 4) == 0);
        chk("t4_ov", int'(out_valid), 1);
        chk("t4_count", int'(count), 4);
        chk_value("t4_value", -8);
        handshake("t4");

        // Reset mid-window discards partial ones
        pulse_start();
        for (int i = 0; i < 9; i++) send_bit((i % 2) == 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t5_count_rst", int'(count), 0);
        chk("t5_ov_rst", int'(out_valid), 0);
        chk("t5_xr_rst", int'(x_ready), 0);
        chk("t5_busy_rst", int'(busy), 0);
        chk_value("t5_value_rst", 0);
        pulse_start();
        for (int i = 0; i < L; i++) send_bit(i < 3);
        chk("t5_ov", int'(out_valid), 1);
        chk("t5_count", int'(count), 3);
        chk_value("t5_value", -10);
        handshake("t5");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
